// File: rtl/tx_symbol_src.sv
// Test-symbol source for the SRRC TX filter. Produces a zero-stuffed, 4 samples/symbol
// stream: a delayed single impulse, a Gray-mapped 4-level PRBS, or a constant symbol.
module tx_symbol_src #(
    parameter int unsigned        IMP_DELAY = 8,
    parameter logic [21:0]        LFSR_SEED = 22'h3FFFFF,
    parameter logic signed [17:0] SYM_P3    = 18'sd98304,
    parameter logic signed [17:0] SYM_P1    = 18'sd32768,
    parameter logic signed [17:0] SYM_N1    = -18'sd32768,
    parameter logic signed [17:0] SYM_N3    = -18'sd98304
) (
    input  logic                     sys_clk,
    input  logic                     reset,
    input  logic                     sam_clk_en,
    input  logic                     sym_clk_en,
    input  logic [1:0]               mode,
    input  logic                     start,
    input  logic                     stop,
    output logic signed [17:0]       symbol_out,
    output logic                     sym_strobe,
    output logic                     busy,
    output logic                     done
);

    localparam int DATA_W = 18;
    localparam logic [7:0] DLY_LAST = 8'(IMP_DELAY - 1);

    typedef enum logic [1:0] {IDLE, DELAY, EMIT, RUN} state_t;

    state_t                    state, state_nx;
    logic [1:0]                mode_q, mode_nx;
    logic [7:0]                dly_cnt, dly_cnt_nx;
    logic [21:0]               lfsr, lfsr_nx;
    logic signed [DATA_W-1:0]  sym_nx;
    logic                      strobe_nx;
    logic                      done_nx;

    // x^22 + x^21 + 1, shifting left with feedback into bit 0
    function automatic logic [21:0] lfsr_step(input logic [21:0] v);
        return {v[20:0], v[21] ^ v[20]};
    endfunction

    function automatic logic signed [DATA_W-1:0] gray_map(input logic [1:0] b);
        case (b)
            2'b00:   return SYM_N3;
            2'b01:   return SYM_N1;
            2'b11:   return SYM_P1;
            default: return SYM_P3;
        endcase
    endfunction

    assign busy = (state != IDLE);

    always_comb begin
        state_nx   = state;
        mode_nx    = mode_q;
        dly_cnt_nx = dly_cnt;
        lfsr_nx    = lfsr;
        sym_nx     = symbol_out;
        strobe_nx  = 1'b0;
        done_nx    = 1'b0;

        // Every sample defaults to zero; only symbol positions in EMIT/RUN carry data.
        if (sam_clk_en)
            sym_nx = '0;

        if (stop) begin
            state_nx   = IDLE;
            dly_cnt_nx = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_nx    = mode;
                        lfsr_nx    = LFSR_SEED;
                        dly_cnt_nx = '0;
                        case (mode)
                            2'b01:        state_nx = DELAY;
                            2'b10, 2'b11: state_nx = RUN;
                            default:      state_nx = IDLE;
                        endcase
                    end
                end
                DELAY: begin
                    if (sym_clk_en) begin
                        if (dly_cnt == DLY_LAST) begin
                            dly_cnt_nx = '0;
                            state_nx   = EMIT;
                        end else begin
                            dly_cnt_nx = dly_cnt + 8'd1;
                        end
                    end
                end
                EMIT: begin
                    if (sym_clk_en) begin
                        sym_nx    = SYM_P1;
                        strobe_nx = 1'b1;
                        done_nx   = 1'b1;
                        state_nx  = IDLE;
                    end
                end
                RUN: begin
                    if (sym_clk_en) begin
                        strobe_nx = 1'b1;
                        if (mode_q == 2'b10) begin
                            sym_nx  = gray_map(lfsr[1:0]);
                            lfsr_nx = lfsr_step(lfsr_step(lfsr));
                        end else begin
                            sym_nx  = SYM_P1;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            mode_q     <= 2'b00;
            dly_cnt    <= '0;
            lfsr       <= LFSR_SEED;
            symbol_out <= '0;
            sym_strobe <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            mode_q     <= mode_nx;
            dly_cnt    <= dly_cnt_nx;
            lfsr       <= lfsr_nx;
            symbol_out <= sym_nx;
            sym_strobe <= strobe_nx;
            done       <= done_nx;
        end
    end

endmodule

// File: tb/tb_tx_symbol_src.sv
// Scoreboard bench for tx_symbol_src: expected symbols are queued when a mode is started
// and popped on every sym_strobe; all other samples must be zero.
module tb_tx_symbol_src;

    logic                sys_clk = 1'b0;
    logic                reset = 1'b1;
    logic                sam_clk_en = 1'b0;
    logic                sym_clk_en = 1'b0;
    logic [1:0]          mode = 2'b00;
    logic                start = 1'b0;
    logic                stop = 1'b0;
    logic signed [17:0]  symbol_out;
    logic                sym_strobe;
    logic                busy;
    logic                done;

    tx_symbol_src dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .sam_clk_en (sam_clk_en),
        .sym_clk_en (sym_clk_en),
        .mode       (mode),
        .start      (start),
        .stop       (stop),
        .symbol_out (symbol_out),
        .sym_strobe (sym_strobe),
        .busy       (busy),
        .done       (done)
    );

    initial forever #20 sys_clk = ~sys_clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          exp_q[$];
    logic [3:0]  phase = 4'd0;
    logic        was_sym, was_sam;
    int          cyc = 0;
    int          sym_seen = 0;
    int          done_cnt = 0;
    int          last_strobe = -1;
    bit          gap_chk = 1'b0;
    bit          imp_chk = 1'b0;
    logic [21:0] ref_lfsr;

    task automatic check(input string tag, input longint got, input longint expv);
        n_cmp++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, expv, cyc);
        end
    endtask

    function automatic logic [21:0] ref_step(input logic [21:0] v);
        logic fb;
        fb = v[21] ^ v[20];
        return {v[20:0], fb};
    endfunction

    function automatic int ref_map(input logic [1:0] b);
        case (b)
            2'b00:   return -98304;
            2'b01:   return -32768;
            2'b11:   return 32768;
            default: return 98304;
        endcase
    endfunction

    // One sys_clk: sample at the rising edge, check outputs and drive inputs on the falling edge.
    task automatic step();
        @(posedge sys_clk);
        was_sym = sym_clk_en;
        was_sam = sam_clk_en;
        @(negedge sys_clk);
        cyc++;
        start = 1'b0;
        stop  = 1'b0;
        phase = phase + 4'd1;
        sam_clk_en = (phase[1:0] == 2'd0);
        sym_clk_en = (phase == 4'd0);
        if (was_sym) sym_seen++;
        if (done) begin
            done_cnt++;
            check("done_busy", longint'(busy), 0);
            check("done_strobe", longint'(sym_strobe), 1);
        end
        if (sym_strobe) begin
            check("strobe_align", longint'(was_sym), 1);
            if (exp_q.size() == 0) begin
                check("unexp_strobe", longint'(sym_strobe), 0);
            end else begin
                check("sym", longint'(symbol_out), longint'(exp_q.pop_front()));
            end
            if (imp_chk) check("imp_pos", longint'(sym_seen), 9);
            if (gap_chk && last_strobe >= 0) check("strobe_gap", longint'(cyc - last_strobe), 16);
            last_strobe = cyc;
        end else if (was_sam) begin
            check("zero_smp", longint'(symbol_out), 0);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget && exp_q.size() > 0; i++) step();
        check(tag, longint'(exp_q.size()), 0);
    endtask

    task automatic push_prbs(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(ref_map(ref_lfsr[1:0]));
            ref_lfsr = ref_step(ref_step(ref_lfsr));
        end
    endtask

    initial begin
        // Reset state
        run(3);
        check("rst_out", longint'(symbol_out), 0);
        check("rst_strobe", longint'(sym_strobe), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        reset = 1'b0;
        run(20);

        // Mode OFF start stays idle
        mode = 2'b00; start = 1'b1;
        run(2);
        check("off_busy", longint'(busy), 0);

        // Impulse
        mode = 2'b01; start = 1'b1;
        exp_q.push_back(32768);
        done_cnt = 0;
        step();
        sym_seen = 0;
        imp_chk = 1'b1;
        run(40);
        check("imp_busy", longint'(busy), 1);
        mode = 2'b10;
        run(190);
        imp_chk = 1'b0;
        check("imp_drain", longint'(exp_q.size()), 0);
        check("imp_done_cnt", longint'(done_cnt), 1);
        check("imp_idle", longint'(busy), 0);

        // Start/stop collision in IDLE
        mode = 2'b01; start = 1'b1; stop = 1'b1; done_cnt = 0;
        step();
        check("coll_busy", longint'(busy), 0);
        run(192);
        check("coll_done", longint'(done_cnt), 0);

        // Stop during DELAY
        mode = 2'b01; start = 1'b1;
        run(64);
        check("dly_busy", longint'(busy), 1);
        stop = 1'b1;
        step();
        check("dly_stop_busy", longint'(busy), 0);
        run(192);
        check("dly_done", longint'(done_cnt), 0);

        // PRBS with mode change while running
        mode = 2'b10; start = 1'b1;
        ref_lfsr = 22'h3FFFFF;
        push_prbs(400);
        gap_chk = 1'b1; last_strobe = -1;
        for (int i = 0; i < 4000 && exp_q.size() > 200; i++) step();
        mode = 2'b11;
        drain("prbs_drain", 4000);
        stop = 1'b1;
        step();
        gap_chk = 1'b0;
        check("prbs_stop_busy", longint'(busy), 0);
        run(40);

        // CONST
        mode = 2'b11; start = 1'b1;
        for (int i = 0; i < 20; i++) exp_q.push_back(32768);
        gap_chk = 1'b1; last_strobe = -1;
        drain("const_drain", 400);
        stop = 1'b1;
        step();
        gap_chk = 1'b0;
        run(40);
        check("const_idle", longint'(busy), 0);

        // Reset mid PRBS, then LFSR must hold the seed
        mode = 2'b10; start = 1'b1;
        ref_lfsr = 22'h3FFFFF;
        push_prbs(10);
        drain("rst_prbs_drain", 400);
        reset = 1'b1;
        run(11);
        check("rstw_out", longint'(symbol_out), 0);
        check("rstw_strobe", longint'(sym_strobe), 0);
        check("rstw_busy", longint'(busy), 0);
        check("rstw_done", longint'(done), 0);
        run(11);
        reset = 1'b0;
        run(2);
        check("rst_lfsr", longint'(dut.lfsr), longint'(22'h3FFFFF));
        check("rst_idle", longint'(busy), 0);
        run(48);

        // Fresh PRBS after reset restarts from the seed
        mode = 2'b10; start = 1'b1;
        ref_lfsr = 22'h3FFFFF;
        push_prbs(8);
        drain("prbs2_drain", 400);
        stop = 1'b1;
        run(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tx_symbol_src.md
TX_SYMBOL_SRC -- requirements
Module: tx_symbol_src

Interface (parameters)
REQ-001 SHALL have parameter IMP_DELAY, default 8, number of symbol periods between start and the impulse in IMPULSE mode (range 1..255).
REQ-002 SHALL have parameter LFSR_SEED, default 22'h3FFFFF, PRBS seed loaded on reset and on every start; value 0 is illegal.
REQ-003 SHALL have parameters SYM_P3, SYM_P1, SYM_N1, SYM_N3, defaults 18'sd98304, 18'sd32768, -18'sd32768, -18'sd98304 (1s17 format: +/-0.75, +/-0.25).

Interface (ports)
REQ-004 SHALL have: sys_clk, input, 1, system clock (25 MHz).
REQ-005 SHALL have: reset, input, 1, asynchronous, active-high.
REQ-006 SHALL have: sam_clk_en, input, 1, one-cycle sample-rate enable (every 4 sys_clk).
REQ-007 SHALL have: sym_clk_en, input, 1, one-cycle symbol-rate enable (every 16 sys_clk), always coincident with a sam_clk_en.
REQ-008 SHALL have: mode, input, 2, 00 OFF, 01 IMPULSE, 10 PRBS, 11 CONST.
REQ-009 SHALL have: start, input, 1, single-cycle request to begin the selected mode.
REQ-010 SHALL have: stop, input, 1, single-cycle request to abort and return to IDLE.
REQ-011 SHALL have: symbol_out, output, 18 signed, zero-stuffed 4-sample/symbol stream to the SRRC TX filter.
REQ-012 SHALL have: sym_strobe, output, 1, high for the one cycle in which symbol_out takes a symbol-position sample.
REQ-013 SHALL have: busy, output, 1, high in any state other than IDLE.
REQ-014 SHALL have: done, output, 1, one-cycle pulse when an IMPULSE sequence completes.

Function
REQ-015 SHALL implement states IDLE, DELAY, EMIT, RUN; transitions are evaluated on sys_clk edges only.
REQ-016 SHALL, in IDLE on start, latch mode into an internal register and reload LFSR with LFSR_SEED; mode 01 -> DELAY, 10 or 11 -> RUN, 00 -> stays IDLE.
REQ-017 SHALL ignore changes on the mode input outside IDLE; start outside IDLE is ignored.
REQ-018 SHALL, in DELAY, count sym_clk_en pulses and enter EMIT after IMP_DELAY counted pulses.
REQ-019 SHALL, in EMIT, drive SYM_P1 on the next sym_clk_en sample, then go to IDLE and assert done for exactly one cycle at that same edge.
REQ-020 SHALL, in RUN with latched mode 10, output on each sym_clk_en the symbol given by lfsr[1:0] with Gray map 00->SYM_N3, 01->SYM_N1, 11->SYM_P1, 10->SYM_P3, then advance LFSR two steps.
REQ-021 SHALL step the LFSR as: fb = lfsr[21]^lfsr[20]; lfsr <= {lfsr[20:0], fb} (x^22+x^21+1, period 2^22-1).
REQ-022 SHALL, in RUN with latched mode 11, output SYM_P1 on every sym_clk_en sample.
REQ-023 SHALL update symbol_out only on sam_clk_en; non-symbol samples (sam_clk_en without sym_clk_en) and all samples in IDLE/DELAY are 18'sd0.
REQ-024 SHALL register symbol_out and sym_strobe one sys_clk after the enabling edge; symbol_out holds between sam_clk_en pulses.
REQ-025 SHALL, on stop in any state, go to IDLE at the next edge; symbol_out forced to 0 at the next sam_clk_en; done not asserted.
REQ-026 SHALL give stop priority over start when both are high in the same cycle.
REQ-027 SHALL not advance the LFSR outside RUN or when sym_clk_en is low.

Reset
REQ-028 SHALL, while reset is high, hold: state IDLE, symbol_out 0, sym_strobe 0, busy 0, done 0, delay counter 0, LFSR LFSR_SEED, latched mode 00.
REQ-029 SHALL, on reset asserted mid-sequence, abandon the sequence immediately without a done pulse; resumes only on a new start.

Verification
REQ-030 Reset: assert reset 880 ns during PRBS RUN -> all outputs 0 within the reset window, LFSR = 22'h3FFFFF after release.
REQ-031 Impulse: mode=01, start, IMP_DELAY=8 -> exactly one nonzero symbol_out = 32768 on the 9th sym_clk_en after start, done pulses once, busy falls same edge.
REQ-032 PRBS: mode=10, start -> first symbol 32768 (seed bits 11), 2^21 consecutive symbols match a reference LFSR model, 3 of 4 samples per symbol zero.
REQ-033 CONST: mode=11 -> symbol_out sequence 32768,0,0,0 repeating, sym_strobe every 16 cycles.
REQ-034 Stop/start collision: start and stop high same cycle in IDLE -> remains IDLE, busy 0; stop during DELAY -> no impulse, no done.
REQ-035 Mode change in RUN: switch mode 10->11 while running -> PRBS output continues unchanged until stop.
